gpp_field_extract: RTL and testbench
====================================

// Module: gpp_field_extract
// PURPOSE
//  Parametrised successor to the fixed-stage packet parser. Taps a word stream (no backpressure)
//  and extracts NF header fields at run-time-configured bit offsets and lengths, including fields
//  that straddle a word boundary. Sits beside the datapath and feeds lookup/classify logic.
// PARAMETERS
//  DW    32  stream word width, bits
//  NF    4   number of extracted fields
//  FW    16  max field length, bits; FW <= DW, so a field spans at most two words
//  OFFW  9   width of bit-offset config (offsets 0..2^OFFW-1 from packet start)
//  LENW  5   width of length config (len 0 = field disabled; len > FW treated as FW)
// PORTS
//  clk       in   1        clock, all logic rising-edge
//  reset     in   1        asynchronous, active-high reset
//  din       in   DW       stream word; bit DW-1 is packet bit offset 0 of that word (MSB-first)
//  din_v     in   1        word valid; each din_v cycle is one accepted beat
//  din_sop   in   1        first word of packet; qualified by din_v
//  din_eop   in   1        last word of packet; qualified by din_v
//  cfg_off   in   NF*OFFW  per-field bit offset; sampled on sop beat
//  cfg_len   in   NF*LENW  per-field length; sampled on sop beat
//  f_data    out  NF*FW    field values, right-justified, zero-extended
//  f_v       out  NF       one-cycle strobe per field: f_data slice updated
//  pkt_done  out  1        one-cycle strobe, cycle after eop beat
//  pkt_err   out  1        present only with GPP_SHORT_PKT_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, word count 0, f_data 0, f_v 0, pkt_done 0, pkt_err 0, shadow cfg 0.
//  - FSM IDLE: din_v&din_sop -> beat is word 0, latch cfg into shadow regs; -> BODY unless din_eop.
//    IDLE: din_v without sop -> beat ignored, stay IDLE.
//  - FSM BODY: din_v -> word count +1; din_eop -> IDLE. din_v&din_sop in BODY -> abort current
//    packet (no pkt_done, pending partial fields dropped), treat beat as word 0 of new packet.
//  - Beat k covers packet bits [k*DW, k*DW+DW). Per field, bits overlapping the beat are shifted
//    into the field accumulator; field completes on the beat holding bit off+len-1.
//  - Latency: f_data slice and f_v[i] registered, asserted cycle after completing beat. Multiple
//    fields may complete on same beat -> multiple f_v bits in same cycle.
//  - f_data held until that field completes in a later packet; not cleared at sop.
//  - Word count saturates at max; no wrap. Fields with off+len beyond 2^OFFW never complete.
//  - Gaps (din_v=0) between beats allowed anywhere; no state change during gaps.
//  - Single-beat packet (sop&eop): fields inside word 0 complete; pkt_done next cycle.
//  - Reset mid-packet: immediate return to reset values; next packet needs a fresh sop.
// CONFIGURATION
//  - GPP_SHORT_PKT_ERR_EN defined: pkt_err port exists; pulses with pkt_done when any enabled
//    field (len != 0) had not completed by the eop beat; those fields keep old f_data, no f_v.
//  - Not defined: no pkt_err port, no completion tracking; incomplete fields silently dropped.
// STRUCTURE
//  - Package gpp_pkg: state enum (IDLE, BODY), default DW/FW/OFFW/LENW constants, field cfg
//    struct {off, len}.
//  - Sub-module gpp_field_slot: one per field via generate; holds shadow cfg, overlap compute,
//    accumulator, f_data/f_v regs, done flag. Top holds FSM, word counter, pkt_done/pkt_err.
// TESTING
//  - f0 off=0 len=16; sop+eop beat din=0xABCD1234 -> next cycle f_data[0]=0xABCD, f_v[0]=1, pkt_done=1.
//  - f1 off=24 len=16; beats 0x000000AA,0xBB000000 (gap of 3 idle cycles) -> f1=0xAABB after beat 1 only.
//  - f0 off=0 len=8, f2 off=8 len=4 on 0x5A3xxxxx -> f_v[0],f_v[2] same cycle, 0x5A and 0x3.
//  - Sop in BODY at word 2: no pkt_done for aborted packet; new packet word 0 fields captured.
//  - Reset asserted mid-packet -> all outputs 0 at once; beats without sop after release ignored.
//  - With GPP_SHORT_PKT_ERR_EN: f3 off=40 len=8, 1-word packet -> pkt_err=1, f_v[3]=0, f3 unchanged.

Source files
------------

// File: rtl/gpp_pkg.sv
// rtl/gpp_pkg.sv - shared types and default sizes for the generic packet field extractor
// Contents: default stream/field geometry, FSM state enum, per-field config struct.
package gpp_pkg;

  localparam int GPP_DW   = 32;  // stream word width
  localparam int GPP_NF   = 4;   // number of extracted fields
  localparam int GPP_FW   = 16;  // max field length
  localparam int GPP_OFFW = 9;   // bit-offset config width
  localparam int GPP_LENW = 5;   // length config width

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } gpp_state_t;

  typedef struct packed {
    logic [GPP_OFFW-1:0] off;
    logic [GPP_LENW-1:0] len;
  } gpp_fld_cfg_t;

endpackage

// File: rtl/gpp_field_slot.sv
// rtl/gpp_field_slot.sv - one field extractor: shadow cfg, boundary accumulator, output regs
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          sop beat accepted this cycle (cfg_off/cfg_len are live, not shadowed)
//   beat           word accepted this cycle as part of a packet
//   word           packet word index of the current beat (saturating)
//   din            current stream word, MSB = lowest packet bit
//   cfg_off/len    live config, latched on start
//   f_data, f_v    registered field value and one-cycle completion strobe
//   pend           (GPP_SHORT_PKT_ERR_EN only) field enabled but not complete after this beat
module gpp_field_slot
  import gpp_pkg::*;
#(
  parameter int DW   = GPP_DW,
  parameter int FW   = GPP_FW,
  parameter int OFFW = GPP_OFFW,
  parameter int LENW = GPP_LENW,
  parameter int WCW  = GPP_OFFW - $clog2(GPP_DW)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            beat,
  input  logic [WCW-1:0]  word,
  input  logic [DW-1:0]   din,
  input  logic [OFFW-1:0] cfg_off,
  input  logic [LENW-1:0] cfg_len,
  output logic [FW-1:0]   f_data,
  output logic            f_v
`ifdef GPP_SHORT_PKT_ERR_EN
  ,
  output logic            pend
`endif
);

  localparam int SH = $clog2(DW);
  localparam logic [LENW-1:0] FW_LEN = LENW'(FW);

  logic [OFFW-1:0]  sh_off;
  logic [LENW-1:0]  sh_len;
  logic             done;
  logic [FW-1:0]    acc;

  logic [OFFW-1:0]  off;
  logic [LENW-1:0]  len;
  logic [LENW-1:0]  eff_len;
  logic             en;
  logic             done_eff;
  logic [OFFW:0]    end_bit;
  logic [WCW-1:0]   ws;
  logic [WCW:0]     we;
  logic             hit_start;
  logic             hit_end;
  logic [SH-1:0]    shamt;
  logic [FW+DW-1:0] joined;
  logic [FW-1:0]    value;

  // The sop beat already belongs to the new packet, so it uses the live config.
  assign off      = start ? cfg_off : sh_off;
  assign len      = start ? cfg_len : sh_len;
  assign eff_len  = (len > FW_LEN) ? FW_LEN : len;
  assign en       = |len;
  assign done_eff = done & ~start;

  assign end_bit = {1'b0, off} + {{(OFFW+1-LENW){1'b0}}, eff_len} - {{OFFW{1'b0}}, 1'b1};
  assign ws      = off[OFFW-1:SH];
  // One extra bit so fields ending past the offset range never match a word index.
  assign we      = end_bit[OFFW:SH];

  assign hit_end   = beat & en & ~done_eff & ({1'b0, word} == we);
  assign hit_start = beat & en & ~done_eff & (word == ws) & ({1'b0, ws} != we);

  // A field spans at most two words; the head lives in the low FW bits of the earlier word.
  assign joined = {acc, din};
  // DW is a power of two, so DW-1-(end mod DW) is the bitwise complement of the low bits.
  assign shamt  = ~end_bit[SH-1:0];
  assign value  = FW'(joined >> shamt) & ~({FW{1'b1}} << eff_len);

`ifdef GPP_SHORT_PKT_ERR_EN
  assign pend = en & ~(done_eff | hit_end);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_off <= '0;
      sh_len <= '0;
      done   <= 1'b0;
      acc    <= '0;
      f_data <= '0;
      f_v    <= 1'b0;
    end else begin
      if (start) begin
        sh_off <= cfg_off;
        sh_len <= cfg_len;
      end
      if (beat) begin
        done <= done_eff | hit_end;
      end
      if (hit_start) begin
        acc <= din[FW-1:0];
      end
      f_v <= hit_end;
      if (hit_end) begin
        f_data <= value;
      end
    end
  end

endmodule

// File: rtl/gpp_field_extract.sv
// rtl/gpp_field_extract.sv - stream tap extracting NF run-time configured header fields
// Optional feature macro: GPP_SHORT_PKT_ERR_EN (adds pkt_err, flags fields missing at eop).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   din/din_v         stream word and valid (no backpressure)
//   din_sop/din_eop   packet delimiters, qualified by din_v
//   cfg_off/cfg_len   per-field offset/length, sampled on the sop beat
//   f_data/f_v        per-field value (right-justified) and completion strobe
//   pkt_done          strobe the cycle after an eop beat
//   pkt_err           strobe with pkt_done when an enabled field did not complete
module gpp_field_extract
  import gpp_pkg::*;
#(
  parameter int DW   = GPP_DW,
  parameter int NF   = GPP_NF,
  parameter int FW   = GPP_FW,
  parameter int OFFW = GPP_OFFW,
  parameter int LENW = GPP_LENW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      din,
  input  logic               din_v,
  input  logic               din_sop,
  input  logic               din_eop,
  input  logic [NF*OFFW-1:0] cfg_off,
  input  logic [NF*LENW-1:0] cfg_len,
  output logic [NF*FW-1:0]   f_data,
  output logic [NF-1:0]      f_v,
  output logic               pkt_done
`ifdef GPP_SHORT_PKT_ERR_EN
  ,
  output logic               pkt_err
`endif
);

  localparam int SH  = $clog2(DW);
  localparam int WCW = OFFW - SH;
  localparam logic [WCW-1:0] WC_MAX = '1;
  localparam logic [WCW-1:0] WC_ONE = {{(WCW-1){1'b0}}, 1'b1};

  gpp_state_t     state;
  logic [WCW-1:0] wcnt;   // index of the next beat within the packet
  logic [WCW-1:0] word;   // index of the current beat
  logic           start;
  logic           beat;

  // sop is honoured in either state; in BODY it aborts the packet in flight.
  assign start = din_v & din_sop;
  assign beat  = din_v & (din_sop | (state == BODY));
  assign word  = start ? '0 : wcnt;

`ifdef GPP_SHORT_PKT_ERR_EN
  logic [NF-1:0] pend;
`endif

  for (genvar g = 0; g < NF; g++) begin : g_slot
    gpp_field_slot #(
      .DW   (DW),
      .FW   (FW),
      .OFFW (OFFW),
      .LENW (LENW),
      .WCW  (WCW)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .beat    (beat),
      .word    (word),
      .din     (din),
      .cfg_off (cfg_off[g*OFFW +: OFFW]),
      .cfg_len (cfg_len[g*LENW +: LENW]),
      .f_data  (f_data[g*FW +: FW]),
      .f_v     (f_v[g])
`ifdef GPP_SHORT_PKT_ERR_EN
      ,
      .pend    (pend[g])
`endif
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= beat & din_eop;
      if (beat) begin
        wcnt  <= (word == WC_MAX) ? WC_MAX : word + WC_ONE;
        state <= din_eop ? IDLE : BODY;
      end
    end
  end

`ifdef GPP_SHORT_PKT_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_err <= 1'b0;
    end else begin
      pkt_err <= beat & din_eop & (|pend);
    end
  end
`else
  // Without completion tracking, fields missing at eop are simply never reported.
`endif

endmodule

// File: tb/tb_gpp_field_extract.sv
// tb/tb_gpp_field_extract.sv - directed table, hand sequences and random run against a bit-level model
module tb_gpp_field_extract;

  localparam int DW = 32, NF = 4, FW = 16, OFFW = 9, LENW = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic [DW-1:0]      din;
  logic               din_v, din_sop, din_eop;
  logic [NF*OFFW-1:0] cfg_off;
  logic [NF*LENW-1:0] cfg_len;
  logic [NF*FW-1:0]   f_data;
  logic [NF-1:0]      f_v;
  logic               pkt_done;
`ifdef GPP_SHORT_PKT_ERR_EN
  logic               pkt_err;
`endif

  gpp_field_extract dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_v    (din_v),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .cfg_off  (cfg_off),
    .cfg_len  (cfg_len),
    .f_data   (f_data),
    .f_v      (f_v),
    .pkt_done (pkt_done)
`ifdef GPP_SHORT_PKT_ERR_EN
    ,
    .pkt_err  (pkt_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] offs(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [19:0] lens(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  typedef struct {
    logic        v, sop, eop;
    logic [31:0] d;
    logic [35:0] off;
    logic [19:0] len;
    logic [3:0]  exp_fv;
    logic        exp_done;
    int          idx;
    logic [15:0] exp_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic s, input logic e, input logic [31:0] d,
                              input logic [35:0] o, input logic [19:0] l, input logic [3:0] fv,
                              input logic dn, input int idx, input logic [15:0] val);
    vec_t r;
    r.v = v; r.sop = s; r.eop = e; r.d = d; r.off = o; r.len = l;
    r.exp_fv = fv; r.exp_done = dn; r.idx = idx; r.exp_val = val;
    return r;
  endfunction

  // Reference model: packet kept as stored words, fields rebuilt bit by bit.
  logic [31:0] m_words[16];
  bit          m_in_pkt;
  int          m_next;
  bit          m_done[4];
  int          m_off[4];
  int          m_len[4];
  logic [15:0] m_f[4];
  logic [3:0]  m_fv;
  bit          m_pd, m_err;

  task automatic model_reset();
    m_in_pkt = 0; m_next = 0; m_fv = '0; m_pd = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin
      m_done[i] = 0; m_off[i] = 0; m_len[i] = 0; m_f[i] = '0;
    end
    for (int w = 0; w < 16; w++) m_words[w] = '0;
  endtask

  function automatic bit pbit(input int b);
    logic [31:0] w;
    w = m_words[b / 32];
    return w[31 - (b % 32)];
  endfunction

  task automatic model_step();
    int k, l, e;
    logic [15:0] val;
    m_fv = '0; m_pd = 0; m_err = 0;
    if (din_v && (din_sop || m_in_pkt)) begin
      if (din_sop) begin
        k = 0;
        for (int i = 0; i < 4; i++) begin
          m_done[i] = 0;
          m_off[i]  = int'(cfg_off[i*9 +: 9]);
          m_len[i]  = int'(cfg_len[i*5 +: 5]);
        end
      end else begin
        k = m_next;
      end
      m_next = (k < 15) ? k + 1 : 15;
      m_words[k] = din;
      for (int i = 0; i < 4; i++) begin
        l = (m_len[i] > 16) ? 16 : m_len[i];
        if (l != 0 && !m_done[i]) begin
          e = m_off[i] + l - 1;
          if (e / 32 == k) begin
            val = '0;
            for (int b = m_off[i]; b <= e; b++) val = {val[14:0], pbit(b)};
            m_f[i] = val; m_fv[i] = 1'b1; m_done[i] = 1;
          end
        end
      end
      if (din_eop) begin
        m_pd = 1;
        for (int i = 0; i < 4; i++) if (m_len[i] != 0 && !m_done[i]) m_err = 1;
        m_in_pkt = 0;
      end else begin
        m_in_pkt = 1;
      end
    end
  endtask

  task automatic model_cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " f_v"}, 64'(f_v), 64'(m_fv));
    check({tag, " pkt_done"}, 64'(pkt_done), 64'(m_pd));
    check({tag, " f_data"}, 64'(f_data), {m_f[3], m_f[2], m_f[1], m_f[0]});
`ifdef GPP_SHORT_PKT_ERR_EN
    check({tag, " pkt_err"}, 64'(pkt_err), 64'(m_err));
`endif
  endtask

  initial begin
    logic [35:0] c1o, c2o, c3o, c4o;
    logic [19:0] c1l, c2l, c3l, c4l;

    reset = 1'b1; din = '0; din_v = 0; din_sop = 0; din_eop = 0; cfg_off = '0; cfg_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset f_data", 64'(f_data), 64'h0);
    check("reset f_v", 64'(f_v), 64'h0);
    check("reset pkt_done", 64'(pkt_done), 64'h0);
`ifdef GPP_SHORT_PKT_ERR_EN
    check("reset pkt_err", 64'(pkt_err), 64'h0);
`endif
    reset = 1'b0;

    c1o = offs(0, 24, 8, 0);  c1l = lens(16, 16, 4, 0);
    c2o = offs(0, 24, 0, 0);  c2l = lens(0, 16, 0, 0);
    c3o = offs(0, 0, 8, 0);   c3l = lens(8, 0, 4, 0);
    c4o = offs(72, 0, 0, 0);  c4l = lens(8, 8, 0, 0);
    // single-beat packet
    vecs.push_back(mk(1, 1, 1, 32'hABCD1234, c1o, c1l, 4'b0101, 1, 0, 16'hABCD));
    vecs.push_back(mk(0, 0, 0, 32'h0, c1o, c1l, 4'b0000, 0, 2, 16'h000C));
    // straddling field with a 3-cycle gap
    vecs.push_back(mk(1, 1, 0, 32'h000000AA, c2o, c2l, 4'b0000, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 32'h0, c2o, c2l, 4'b0000, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 32'h0, c2o, c2l, 4'b0000, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 32'h0, c2o, c2l, 4'b0000, 0, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 32'hBB000000, c2o, c2l, 4'b0010, 1, 1, 16'hAABB));
    // two fields completing on the same beat
    vecs.push_back(mk(1, 1, 1, 32'h5A3FFFFF, c3o, c3l, 4'b0101, 1, 0, 16'h005A));
    vecs.push_back(mk(0, 0, 0, 32'h0, c3o, c3l, 4'b0000, 0, 2, 16'h0003));
    // sop in BODY at word 2 aborts: f0 at word 2 must not fire, no pkt_done
    vecs.push_back(mk(1, 1, 0, 32'h01000000, c4o, c4l, 4'b0010, 0, 1, 16'h0001));
    vecs.push_back(mk(1, 0, 0, 32'h00000000, c4o, c4l, 4'b0000, 0, 1, 16'h0001));
    vecs.push_back(mk(1, 1, 0, 32'h02EE0000, c4o, c4l, 4'b0010, 0, 1, 16'h0002));
    vecs.push_back(mk(1, 0, 1, 32'h00000000, c4o, c4l, 4'b0000, 1, 0, 16'h005A));
    // beat in IDLE without sop is ignored
    vecs.push_back(mk(1, 0, 1, 32'hFFFFFFFF, c1o, c1l, 4'b0000, 0, 0, 16'h005A));

    for (int n = 0; n < vecs.size(); n++) begin
      din_v = vecs[n].v; din_sop = vecs[n].sop; din_eop = vecs[n].eop; din = vecs[n].d;
      cfg_off = vecs[n].off; cfg_len = vecs[n].len;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d f_v", n), 64'(f_v), 64'(vecs[n].exp_fv));
      check($sformatf("vec%0d pkt_done", n), 64'(pkt_done), 64'(vecs[n].exp_done));
      check($sformatf("vec%0d f_data[%0d]", n, vecs[n].idx),
            64'(f_data[vecs[n].idx*16 +: 16]), 64'(vecs[n].exp_val));
    end

    // reset mid-packet: outputs clear immediately, later non-sop beats ignored
    din_v = 1; din_sop = 1; din_eop = 0; din = 32'hABCD1234; cfg_off = c1o; cfg_len = c1l;
    @(posedge clk);
    #1;
    check("pre-reset f_v", 64'(f_v), 64'h5);
    din_v = 0; din_sop = 0;
    reset = 1'b1;
    #1;
    check("midreset f_data", 64'(f_data), 64'h0);
    check("midreset f_v", 64'(f_v), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    din_v = 1; din_sop = 0; din_eop = 0; din = 32'h0000FFFF;
    @(posedge clk);
    #1;
    din_eop = 1;
    @(posedge clk);
    #1;
    check("postreset f_v", 64'(f_v), 64'h0);
    din_v = 0; din_eop = 0;
    @(posedge clk);
    #1;
    check("postreset pkt_done", 64'(pkt_done), 64'h0);
    check("postreset f_data", 64'(f_data), 64'h0);

`ifdef GPP_SHORT_PKT_ERR_EN
    // short packet: f3 needs word 1
    din_v = 1; din_sop = 1; din_eop = 1; din = 32'h12345678;
    cfg_off = offs(0, 0, 0, 40); cfg_len = lens(0, 0, 0, 8);
    @(posedge clk);
    #1;
    check("short pkt_err", 64'(pkt_err), 64'h1);
    check("short f_v", 64'(f_v), 64'h0);
    check("short f3", 64'(f_data[63:48]), 64'h0);
    din_eop = 0; din = 32'h0;
    @(posedge clk);
    #1;
    din_sop = 0; din_eop = 1; din = 32'h00C30000;
    @(posedge clk);
    #1;
    check("full pkt_err", 64'(pkt_err), 64'h0);
    check("full f_v", 64'(f_v), 64'h8);
    check("full f3", 64'(f_data[63:48]), 64'h00C3);
    din_v = 0; din_eop = 0;
`endif

    // model-checked phase starts from a clean reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // long packet: word count saturates, fields near the top of the offset range
    cfg_off = offs(480, 504, 0, 500); cfg_len = lens(16, 16, 0, 12);
    for (int w = 0; w < 20; w++) begin
      din_v = 1; din_sop = (w == 0); din_eop = (w == 19); din = $urandom;
      model_cycle($sformatf("sat%0d", w));
    end
    din_v = 0; din_eop = 0;
    model_cycle("sat_tail");

    for (int c = 0; c < 800; c++) begin
      din_v   = ($urandom_range(0, 9) < 7);
      din_sop = ($urandom_range(0, 9) == 0);
      din_eop = ($urandom_range(0, 7) == 0);
      din     = $urandom;
      for (int i = 0; i < 4; i++) begin
        cfg_off[i*9 +: 9] = 9'($urandom_range(0, 160));
        cfg_len[i*5 +: 5] = 5'($urandom_range(0, 20));
      end
      model_cycle($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
